// File: rtl/conv_param_up.sv
// Width up-converter: packs RATIO beats of IN_W bits into one registered OUT_W word,
// with flush of partial words and a ready/valid handshake on both sides.
module conv_param_up #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 1,
  localparam int OUT_W    = IN_W * RATIO,
  localparam int CW       = $clog2(RATIO) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  data_in,
  output logic             ready_in,
  input  logic             flush,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out,
  output logic [CW-1:0]    lanes_out,
  input  logic             ready_out
);

  localparam logic [CW-1:0] LAST_LANE  = CW'(RATIO - 1);
  localparam logic [CW-1:0] FULL_LANES = CW'(RATIO);

  if (IN_W < 1 || RATIO < 2 || (MSB_FIRST != 0 && MSB_FIRST != 1)) begin : g_bad_params
    $error("conv_param_up: IN_W >= 1, RATIO >= 2, MSB_FIRST in {0,1} required");
  end

  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] asm_q;
  logic [OUT_W-1:0] asm_next;
  logic             flush_pend;

  logic             load_ok;
  logic             accept;
  logic             word_done;
  logic             service;
  logic             load;
  logic [CW-1:0]    lanes_next;

  // Bit offset of lane i inside the output word.
  function automatic int lane_lsb(input int i);
    return (MSB_FIRST != 0) ? (RATIO - 1 - i) * IN_W : i * IN_W;
  endfunction

  // The output register can take a new word this cycle.
  assign load_ok = !valid_out || ready_out;

  // Block the last lane while the output is occupied, and block everything
  // while a flush waits, so the partial word being flushed stays frozen.
  assign ready_in = ((cnt != LAST_LANE) || load_ok) && !(flush_pend && !load_ok);

  assign accept     = valid_in && ready_in;
  assign word_done  = accept && (cnt == LAST_LANE);
  assign service    = (flush || flush_pend) && load_ok;
  assign load       = word_done || (service && ((cnt != '0) || accept));
  assign lanes_next = word_done ? FULL_LANES : cnt + CW'(accept);

  // NOTE: always_comb assigns a default before any conditional write, so no latch is inferred.
  always_comb begin
    asm_next = asm_q;
    if (accept) begin
      for (int i = 0; i < RATIO; i++) begin
        if (cnt == CW'(i)) begin
          asm_next[lane_lsb(i) +: IN_W] = data_in;
        end
      end
    end
  end

  // NOTE: the output data register is reset as well, since reset must clear data_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      asm_q      <= '0;
      flush_pend <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      lanes_out  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (load) begin
        data_out  <= asm_next;
        lanes_out <= lanes_next;
        valid_out <= 1'b1;
        cnt       <= '0;
        asm_q     <= '0;
      end else begin
        if (accept) begin
          asm_q <= asm_next;
          cnt   <= cnt + CW'(1);
        end
        if (valid_out && ready_out) begin
          valid_out <= 1'b0;
        end
      end

      if (service) begin
        flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

  a_cnt_range : assert property (@(posedge clk) disable iff (reset) cnt <= LAST_LANE);

  a_out_hold : assert property (@(posedge clk) disable iff (reset)
    (valid_out && !ready_out) |=> (valid_out && $stable(data_out) && $stable(lanes_out)));

endmodule
